// File: rtl/overcook_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : overcook_pkg
//  Purpose  : Shared constants and types for the switch change encoder.
//             NO_CHANGE is the idle code on the 4-bit change bus; state_t is
//             the encoder FSM state.
//  Revision : 1.0  initial release
// ============================================================================
package overcook_pkg;

  localparam logic [3:0] NO_CHANGE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage : overcook_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : One switch lane: 2-flop synchroniser, hold-time debouncer and a
//             one-cycle toggle pulse that is high in the cycle the debounced
//             level shows its new value.
//  Ports    : clk      in  system clock
//             rst_n    in  asynchronous active-low reset
//             i_raw    in  raw (asynchronous) switch level
//             o_stable out debounced level
//             o_tog    out pulse, high while o_stable differs from last cycle
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_tog
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_tog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_tog    <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_tog   <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
        r_stable <= ~r_stable;
        r_cnt    <= '0;
        r_tog    <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_tog    = r_tog;

endmodule : sw_debounce
`default_nettype wire

// File: rtl/switch_change_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : switch_change_encoder
//  Purpose  : Turns raw player switches into single-cycle switch-index codes
//             on o_change (4'hF = no change). Per-switch debounce lanes feed a
//             pending mask; a lowest-index-first FSM emits one code per event
//             followed by GAP_CYCLES idle cycles.
//  Ports    : clk            in   system clock
//             rst_n          in   asynchronous active-low reset
//             i_enable       in   1 = report events, 0 = track silently
//             i_sw_raw       in   raw switch levels [N_SW]
//             o_change       out  toggled switch index for one cycle, else F
//             o_change_valid out  high exactly when o_change != 4'hF
//             o_pending      out  debounced toggles not yet emitted [N_SW]
//             o_sw_stable    out  debounced switch levels [N_SW]
//             o_dropped      out  sticky: toggle while already pending
//  Config   : SWCHG_RISE_ONLY_EN - only 0->1 debounced transitions are events
//  Revision : 1.0  initial release
// ============================================================================
module switch_change_encoder
  import overcook_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GAP_CYCLES      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  input  logic [N_SW-1:0] i_sw_raw,
  output logic [3:0]      o_change,
  output logic            o_change_valid,
  output logic [N_SW-1:0] o_pending,
  output logic [N_SW-1:0] o_sw_stable,
  output logic            o_dropped
);

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_LAST_INT);

  logic [N_SW-1:0] w_stable;
  logic [N_SW-1:0] w_tog;
  logic [N_SW-1:0] w_tog_eff;
  logic [N_SW-1:0] w_clr;
  logic [3:0]      w_lowest;
  logic            w_slot;
  logic            w_launch;

  logic [N_SW-1:0] r_pending;
  logic            r_dropped;
  state_t          r_state;
  logic [GW-1:0]   r_gap_cnt;
  logic [3:0]      r_change;
  logic            r_change_valid;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (i_sw_raw[gi]),
      .o_stable(w_stable[gi]),
      .o_tog   (w_tog[gi])
    );
  end

`ifdef SWCHG_RISE_ONLY_EN
  // o_stable already holds the new level while the toggle pulse is high.
  assign w_tog_eff = w_tog & w_stable;
`else
  assign w_tog_eff = w_tog;
`endif

  // Lowest set pending index wins.
  always_comb begin
    w_lowest = NO_CHANGE;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowest = 4'(i);
    end
  end

  // A code may start from IDLE, or directly as the forced gap ends, so that
  // back-to-back codes are separated by exactly GAP_CYCLES idle cycles.
  always_comb begin
    w_slot = 1'b0;
    case (r_state)
      ST_IDLE: w_slot = 1'b1;
      ST_EMIT: w_slot = (GAP_CYCLES == 0);
      ST_GAP:  w_slot = (r_gap_cnt == c_gap_last);
      default: w_slot = 1'b0;
    endcase
  end

  assign w_launch = w_slot && i_enable && (|r_pending);

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_SW; i++) begin
      w_clr[i] = w_launch && (w_lowest == 4'(i));
    end
  end

  // Pending mask and sticky drop flag. A toggle landing on the bit being
  // cleared this cycle re-arms it without counting as a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_dropped <= 1'b0;
    end else if (!i_enable) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_tog_eff;
      if (|(w_tog_eff & r_pending & ~w_clr)) r_dropped <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_gap_cnt      <= '0;
      r_change       <= NO_CHANGE;
      r_change_valid <= 1'b0;
    end else begin
      r_change       <= NO_CHANGE;
      r_change_valid <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_EMIT: begin
          if (GAP_CYCLES > 0) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) r_state <= ST_IDLE;
          else                         r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_launch) begin
        r_state        <= ST_EMIT;
        r_change       <= w_lowest;
        r_change_valid <= 1'b1;
      end
    end
  end

  assign o_change       = r_change;
  assign o_change_valid = r_change_valid;
  assign o_pending      = r_pending;
  assign o_sw_stable    = w_stable;
  assign o_dropped      = r_dropped;

endmodule : switch_change_encoder
`default_nettype wire
